// File: rtl/dro_deser_pkg.sv
// Shared types and defaults for the DRO output deserializer.
package dro_deser_pkg;
  typedef enum logic {IDLE, WIN} state_t;

  localparam int WORD_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Level counter must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dro_deser_fifo.sv
// Synchronous word FIFO; a push into a full FIFO only lands if a pop frees a slot that same cycle.
module dro_deser_fifo
  import dro_deser_pkg::*;
#(
  parameter int W = WORD_W_DEF,
  parameter int D = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [lvl_w(D)-1:0]    level
);
  localparam int AW = $clog2(D);
  localparam int LW = lvl_w(D);

  logic [D-1:0][W-1:0] mem;
  logic [AW-1:0]       wp, rp;
  logic                do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(D));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  // Pointers are power-of-2 wide, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/dro_out_deserializer.sv
// Packs one bit per DRO clock window (1 = DRO out pulse seen) LSB-first into words, buffered in a FIFO.
// Optional X-checking on sfq_d (err_x port) when DRO_DESER_XCHECK_EN is defined.
module dro_out_deserializer
  import dro_deser_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sfq_clk,
  input  logic                          sfq_d,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [lvl_w(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                          err_ovf,
  output logic                          err_multi
`ifdef DRO_DESER_XCHECK_EN
  , output logic                        err_x
`endif
);
  localparam int CW = $clog2(WORD_W);

  state_t              state;
  logic                clk_q, clk_qq, d_q, d_qq;
  logic                clk_edge, d_edge, hit, hit_n;
  logic [CW-1:0]       cnt;
  logic [WORD_W-1:0]   shreg, shreg_n, word;
  logic                push, pop, full, empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q  <= 1'b0;
      clk_qq <= 1'b0;
      d_q    <= 1'b0;
      d_qq   <= 1'b0;
    end else begin
      clk_q  <= sfq_clk;
      clk_qq <= clk_q;
`ifdef DRO_DESER_XCHECK_EN
      d_q    <= sfq_d;
`else
      d_q    <= (sfq_d === 1'b1);
`endif
      d_qq   <= d_q;
    end
  end

  assign clk_edge = clk_q & ~clk_qq;
  assign d_edge   = d_q & ~d_qq;
  assign pop      = out_valid & out_ready;

  // A data edge coincident with the closing clock edge still counts for the closing window.
  always_comb begin
    hit_n = hit | d_edge;
`ifdef DRO_DESER_XCHECK_EN
    if (d_q !== 1'b0 && d_q !== 1'b1) hit_n = 1'bx;
`endif
    shreg_n      = shreg;
    shreg_n[cnt] = hit_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hit       <= 1'b0;
      shreg     <= '0;
      word      <= '0;
      push      <= 1'b0;
      err_ovf   <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      push <= 1'b0;
      if (push && full && !pop) err_ovf <= 1'b1;
      case (state)
        IDLE: if (clk_edge) begin
          state <= WIN;
          hit   <= 1'b0;
        end
        WIN: begin
          if (d_edge && hit) err_multi <= 1'b1;
          if (clk_edge) begin
            hit <= 1'b0;
            if (cnt == CW'(WORD_W - 1)) begin
              word  <= shreg_n;
              push  <= 1'b1;
              cnt   <= '0;
              shreg <= '0;
            end else begin
              shreg <= shreg_n;
              cnt   <= cnt + 1'b1;
            end
          end else begin
            hit <= hit_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRO_DESER_XCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_x <= 1'b0;
    else if (d_q !== 1'b0 && d_q !== 1'b1) begin
      err_x <= 1'b1;
      $display("%m: X on sfq_d (DRO timing violation) at %0d", $stime);
    end
  end
`endif

  dro_deser_fifo #(.W(WORD_W), .D(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (word),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign out_valid = ~empty;
endmodule

// File: tb/tb_dro_out_deserializer.sv
// Directed bench for dro_out_deserializer: table of window streams plus multi-cycle corner sequences.
module tb_dro_out_deserializer;
  logic       clk = 1'b0;
  logic       rst, sfq_clk, sfq_d, out_ready;
  logic [7:0] out_data;
  logic       out_valid, err_ovf, err_multi;
  logic [2:0] fifo_level;
`ifdef DRO_DESER_XCHECK_EN
  logic       err_x;
`endif

  dro_out_deserializer #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sfq_clk    (sfq_clk),
    .sfq_d      (sfq_d),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .err_ovf    (err_ovf),
    .err_multi  (err_multi)
`ifdef DRO_DESER_XCHECK_EN
    , .err_x    (err_x)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];

  // Record every accepted word (handshake seen away from the active edge).
  always @(negedge clk)
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One DRO clock marker followed by the window contents; 10 clk per window.
  task automatic marker_win(input bit b, input bit dbl = 1'b0, input bit coinc = 1'b0);
    int used;
    sfq_clk = 1'b1;
    if (coinc) sfq_d = 1'b1;
    tick(2);
    sfq_clk = 1'b0;
    sfq_d   = 1'b0;
    tick(1);
    used = 3;
    if (b) begin
      sfq_d = 1'b1; tick(2); sfq_d = 1'b0; tick(1); used += 3;
    end
    if (dbl) begin
      sfq_d = 1'b1; tick(2); sfq_d = 1'b0; tick(1); used += 3;
    end
    tick(10 - used);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) marker_win(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; sfq_clk = 1'b0; sfq_d = 1'b0; out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    got.delete();
  endtask

  typedef struct {
    logic [7:0] stream;   // window bits in arrival order, first window leftmost
    logic [7:0] exp_word; // LSB-first packed word
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'b1011_0001, 8'h8D};
    vecs[1] = '{8'b0000_0001, 8'h80};
    vecs[2] = '{8'b1000_0000, 8'h01};
    vecs[3] = '{8'b1111_0000, 8'h0F};
    vecs[4] = '{8'b0101_0101, 8'hAA};
    vecs[5] = '{8'b1111_1111, 8'hFF};
    vecs[6] = '{8'b0000_0000, 8'h00};

    // Reset state
    rst = 1'b1; sfq_clk = 1'b0; sfq_d = 1'b0; out_ready = 1'b0;
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_multi", err_multi, 0);
    do_reset();

    // Test 1: markers 1..9, data after markers 1,3,4,8; latency check on the closing marker
    send_word(8'h8D);
    sfq_clk = 1'b1;
    tick(1);
    tick(1);
    chk("t1_valid_n+1", out_valid, 0);
    tick(1);
    chk("t1_valid_n+2", out_valid, 1);
    sfq_clk = 1'b0;
    tick(7);
    chk("t1_data", out_data, 8'h8D);
    chk("t1_level", fifo_level, 1);

    // Table: continuous stream, consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++)
      for (int i = 0; i < 8; i++) marker_win(vecs[v].stream[7-i]);
    marker_win(1'b0);
    tick(2);
    chk("tbl_count", got.size(), 7);
    for (int v = 0; v < 7; v++)
      chk($sformatf("tbl_word%0d", v), (v < got.size()) ? got[v] : 8'hxx, vecs[v].exp_word);
    chk("tbl_level", fifo_level, 0);

    // Test 2: overflow with consumer stalled
    do_reset();
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44); send_word(8'h55);
    chk("t2_level4", fifo_level, 4);
    chk("t2_no_ovf_yet", err_ovf, 0);
    marker_win(1'b0);
    chk("t2_ovf", err_ovf, 1);
    chk("t2_level_cap", fifo_level, 4);
    for (int k = 0; k < 3; k++) begin
      chk("t2_stable", out_data, 8'h11);
      tick(1);
    end
    got.delete();
    out_ready = 1'b1;
    tick(6);
    out_ready = 1'b0;
    chk("t2_drain_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_order%0d", k), (k < got.size()) ? got[k] : 8'hxx, 8'(8'h11 * (k + 1)));
    chk("t2_level0", fifo_level, 0);
    chk("t2_ovf_sticky", err_ovf, 1);

    // Test 3: sfq_d edge coincident with closing marker
    do_reset();
    marker_win(1'b0);
    marker_win(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) marker_win(1'b0);
    marker_win(1'b0);
    chk("t3_word", out_data, 8'h01);
    chk("t3_multi", err_multi, 0);

    // Test 4: two pulses in one window
    do_reset();
    marker_win(1'b1, 1'b1);
    chk("t4_multi_set", err_multi, 1);
    marker_win(1'b0); marker_win(1'b1);
    for (int i = 0; i < 5; i++) marker_win(1'b0);
    marker_win(1'b0);
    chk("t4_word", out_data, 8'h05);
    chk("t4_multi_sticky", err_multi, 1);
    rst = 1'b1;
    tick(1);
    chk("t4_multi_clr", err_multi, 0);

    // Test 5: reset mid-word with two words queued
    do_reset();
    send_word(8'hAA); send_word(8'h55);
    for (int i = 0; i < 6; i++) marker_win(i[0]);
    chk("t5_level2", fifo_level, 2);
    chk("t5_valid", out_valid, 1);
    rst = 1'b1;
    #2;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_level", fifo_level, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    got.delete();
    out_ready = 1'b1;
    send_word(8'h3C);
    marker_win(1'b0);
    tick(2);
    chk("t5_count", got.size(), 1);
    chk("t5_word", (got.size() > 0) ? got[0] : 8'hxx, 8'h3C);

`ifdef DRO_DESER_XCHECK_EN
    // Test 6: X on sfq_d inside window 2
    do_reset();
    marker_win(1'b0); marker_win(1'b0);
    sfq_clk = 1'b1; tick(2); sfq_clk = 1'b0; tick(1);
    sfq_d = 1'bx; tick(1); sfq_d = 1'b0; tick(6);
    for (int i = 0; i < 5; i++) marker_win(1'b0);
    marker_win(1'b0);
    chk("t6_err_x", err_x, 1);
    checks++;
    if (out_data[2] !== 1'bx) begin
      errors++;
      $display("FAIL t6_xbit: got %b expected x", out_data[2]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
